seq_det_sched: RTL and testbench

//  Round-robin scheduler sharing one 2-bit-symbol pattern detector among NCH requesters.
//  Per channel it saves and restores detector context (state, hit counter).

---
 rtl/seq_det_sched_pkg.sv | 15 +
 rtl/seq_det_sched_if.sv | 32 +++
 rtl/seq_det_core.sv | 23 ++
 rtl/seq_det_sched.sv | 97 +++++++++
 tb/tb_seq_det_sched.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/seq_det_sched_pkg.sv
// Shared definitions for the shared-detector scheduler.
// Holds the detector state encodings and the 2-bit symbol codes used by the core and the top.
package seq_det_sched_pkg;

    // Detector states; encoding 3 is unreachable and behaves as ST_IDLE.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_S1   = 2'd1;
    localparam logic [1:0] ST_S10  = 2'd2;

    localparam logic [1:0] SYM_00 = 2'b00;
    localparam logic [1:0] SYM_01 = 2'b01;
    localparam logic [1:0] SYM_10 = 2'b10;
    localparam logic [1:0] SYM_11 = 2'b11;

endpackage

// File: rtl/seq_det_sched_if.sv
// Bus bundle between symbol sources / hit consumer and seq_det_sched.
//   req_valid  channel i offers symbol req_sym[2i+1:2i]
//   req_sym    packed 2-bit symbols
//   req_ready  one-hot or zero grant
//   ch_clr     per-channel context clear
//   hit_valid  one-cycle hit pulse, hit_ch its channel
//   cnt_sel    counter read select, cnt_out the selected hit count
// master: the environment side; slave: the scheduler.
interface seq_det_sched_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CHW = 2,
    parameter int unsigned CW  = 8
);
    logic [NCH-1:0]   req_valid;
    logic [2*NCH-1:0] req_sym;
    logic [NCH-1:0]   req_ready;
    logic [NCH-1:0]   ch_clr;
    logic             hit_valid;
    logic [CHW-1:0]   hit_ch;
    logic [CHW-1:0]   cnt_sel;
    logic [CW-1:0]    cnt_out;

    modport master (
        output req_valid, req_sym, ch_clr, cnt_sel,
        input  req_ready, hit_valid, hit_ch, cnt_out
    );

    modport slave (
        input  req_valid, req_sym, ch_clr, cnt_sel,
        output req_ready, hit_valid, hit_ch, cnt_out
    );
endinterface

// File: rtl/seq_det_core.sv
// Combinational 01,00,{01|10} pattern detector step.
//   state       current context state
//   sym         accepted symbol
//   next_state  state after consuming sym
//   hit         Mealy hit on this symbol
module seq_det_core
    import seq_det_sched_pkg::*;
(
    input  logic [1:0] state,
    input  logic [1:0] sym,
    output logic [1:0] next_state,
    output logic       hit
);
    always_comb begin
        next_state = ST_IDLE;
        case (sym)
            SYM_01:  next_state = ST_S1;
            SYM_00:  next_state = (state == ST_S1) ? ST_S10 : ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
        hit = (state == ST_S10) && ((sym == SYM_01) || (sym == SYM_10));
    end
endmodule

// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one pattern detector among NCH channels.
// Each channel's detector state and saturating hit counter are kept in register arrays and
// muxed into the single core for the granted channel, so every channel sees a private detector.
//   clk    rising-edge clock
//   clr_n  asynchronous active-low reset
//   bus    seq_det_sched_if slave port (requests, grant, clears, hit event, counter read)
module seq_det_sched
    import seq_det_sched_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned CHW = 2,
    parameter int unsigned CW  = 8
) (
    input logic            clk,
    input logic            clr_n,
    seq_det_sched_if.slave bus
);
    logic [NCH-1:0] elig;
    logic [NCH-1:0] gnt;
    logic [CHW-1:0] gnt_id;
    logic [CHW-1:0] idx;
    logic           accept;

    logic [1:0]     ctx_q [NCH];
    logic [CW-1:0]  cnt_q [NCH];
    logic [CHW-1:0] ptr_q;
    logic           hit_valid_q;
    logic [CHW-1:0] hit_ch_q;

    logic [1:0]     cur_state;
    logic [1:0]     cur_sym;
    logic [1:0]     nxt_state;
    logic           hit;

    // A channel being cleared is never granted, so clear always beats accept.
    assign elig = bus.req_valid & ~bus.ch_clr;

    // Search ptr+1, ptr+2, ... with wrap; first eligible channel wins.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        idx    = '0;
        accept = 1'b0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            idx = CHW'((32'(ptr_q) + i) % NCH);
            if (!accept && elig[idx]) begin
                accept      = 1'b1;
                gnt[idx]    = 1'b1;
                gnt_id      = idx;
            end
        end
    end

    assign cur_state = ctx_q[gnt_id];
    assign cur_sym   = bus.req_sym[2*gnt_id +: 2];

    seq_det_core u_core (
        .state      (cur_state),
        .sym        (cur_sym),
        .next_state (nxt_state),
        .hit        (hit)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < int'(NCH); i++) begin
                ctx_q[i] <= ST_IDLE;
                cnt_q[i] <= '0;
            end
            ptr_q       <= CHW'(NCH - 1);
            hit_valid_q <= 1'b0;
            hit_ch_q    <= '0;
        end else begin
            for (int i = 0; i < int'(NCH); i++) begin
                if (bus.ch_clr[i]) begin
                    ctx_q[i] <= ST_IDLE;
                    cnt_q[i] <= '0;
                end else if (gnt[i]) begin
                    ctx_q[i] <= nxt_state;
                    if (hit && (cnt_q[i] != {CW{1'b1}})) begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end
            end
            hit_valid_q <= accept & hit;
            if (accept) begin
                ptr_q    <= gnt_id;
                hit_ch_q <= gnt_id;
            end
        end
    end

    assign bus.req_ready = gnt;
    assign bus.hit_valid = hit_valid_q;
    assign bus.hit_ch    = hit_ch_q;
    assign bus.cnt_out   = (32'(bus.cnt_sel) < NCH) ? cnt_q[bus.cnt_sel] : '0;
endmodule

// File: tb/tb_seq_det_sched.sv
module tb_seq_det_sched;
    localparam int unsigned NCH = 4;
    localparam int unsigned CHW = 2;
    localparam int unsigned CW  = 2;

    logic clk;
    logic clr_n;
    int   n_checks;
    int   n_errors;

    seq_det_sched_if #(.NCH(NCH), .CHW(CHW), .CW(CW)) bus ();

    seq_det_sched #(.NCH(NCH), .CHW(CHW), .CW(CW)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [3:0] v, input logic [1:0] s0, input logic [1:0] s1,
                         input logic [1:0] s2, input logic [1:0] s3, input logic [3:0] clr);
        bus.req_valid = v;
        bus.req_sym   = {s3, s2, s1, s0};
        bus.ch_clr    = clr;
        #1;
    endtask

    task automatic idle();
        apply(4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000);
    endtask

    task automatic check_cnt(input string tag, input int ch, input int unsigned exp);
        bus.cnt_sel = CHW'(ch);
        #1;
        check(tag, bus.cnt_out, exp);
    endtask

    task automatic do_reset();
        idle();
        clr_n = 1'b0;
        #3;
        clr_n = 1'b1;
        tick();
    endtask

    logic [1:0] c0 [4];
    int         i0;
    int         hits;

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        clr_n       = 1'b0;
        bus.req_valid = '0;
        bus.req_sym   = '0;
        bus.ch_clr    = '0;
        bus.cnt_sel   = '0;

        // Reset state
        #12;
        check("rst_hit_valid", bus.hit_valid, 0);
        check("rst_hit_ch", bus.hit_ch, 0);
        check("rst_ready_idle", bus.req_ready, 0);
        for (int c = 0; c < 4; c++) check_cnt("rst_cnt", c, 0);
        clr_n = 1'b1;
        tick();
        apply(4'b1111, 2'b11, 2'b11, 2'b11, 2'b11, 4'b0000);
        check("rst_ch0_first", bus.req_ready, 4'b0001);
        idle();

        // Test 1: ch0 alone 01,00,01
        do_reset();
        apply(4'b0001, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000);
        check("t1_ready", bus.req_ready, 4'b0001);
        tick();
        check("t1_nohit_a", bus.hit_valid, 0);
        apply(4'b0001, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000);
        tick();
        check("t1_nohit_b", bus.hit_valid, 0);
        apply(4'b0001, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000);
        tick();
        check("t1_hit", bus.hit_valid, 1);
        check("t1_hit_ch", bus.hit_ch, 0);
        check_cnt("t1_cnt0", 0, 1);
        idle();
        tick();
        check("t1_pulse_end", bus.hit_valid, 0);

        // Test 2: ch0 01,00,10 and ch1 11,11,11 interleaved
        do_reset();
        c0[0] = 2'b01; c0[1] = 2'b00; c0[2] = 2'b10; c0[3] = 2'b11;
        i0 = 0;
        for (int k = 0; k < 6; k++) begin
            apply(4'b0011, c0[i0], 2'b11, 2'b00, 2'b00, 4'b0000);
            check("t2_grant", bus.req_ready, (k % 2 == 0) ? 4'b0001 : 4'b0010);
            tick();
            if (k % 2 == 0) i0++;
            check("t2_hit_valid", bus.hit_valid, (k == 4) ? 1 : 0);
            if (k == 4) check("t2_hit_ch", bus.hit_ch, 0);
        end
        idle();
        check_cnt("t2_cnt0", 0, 1);
        check_cnt("t2_cnt1", 1, 0);

        // Test 3: isolation between ch0 and ch1
        do_reset();
        hits = 0;
        apply(4'b0001, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000);
        tick(); hits += int'(bus.hit_valid);
        apply(4'b0010, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000);
        check("t3_grant_ch1", bus.req_ready, 4'b0010);
        tick(); hits += int'(bus.hit_valid);
        apply(4'b0001, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000);
        tick(); hits += int'(bus.hit_valid);
        apply(4'b0001, 2'b10, 2'b00, 2'b00, 2'b00, 4'b0000);
        tick(); hits += int'(bus.hit_valid);
        check("t3_hit_ch", bus.hit_ch, 0);
        check("t3_hits", hits, 1);
        // ch1 must still be IDLE: a 10 from S10 would hit
        apply(4'b0010, 2'b00, 2'b10, 2'b00, 2'b00, 4'b0000);
        tick();
        check("t3_ch1_idle", bus.hit_valid, 0);
        idle();
        check_cnt("t3_cnt1", 1, 0);

        // Test 4: clear beats accept on ch2
        do_reset();
        apply(4'b0100, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0000); tick();
        apply(4'b0100, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000); tick();
        apply(4'b0100, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0000); tick();
        check("t4_hit", bus.hit_valid, 1);
        check("t4_hit_ch", bus.hit_ch, 2);
        apply(4'b0100, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000); tick();
        check_cnt("t4_cnt2_pre", 2, 1);
        apply(4'b1100, 2'b00, 2'b00, 2'b01, 2'b11, 4'b0100);
        check("t4_ready_clr", bus.req_ready, 4'b1000);
        tick();
        check("t4_no_hit_clr", bus.hit_valid, 0);
        check_cnt("t4_cnt2_clr", 2, 0);
        apply(4'b0100, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0000);
        tick();
        check("t4_after_clr", bus.hit_valid, 0);
        idle();

        // Test 5: ch3 saturation with CW=2
        do_reset();
        hits = 0;
        for (int r = 0; r < 5; r++) begin
            apply(4'b1000, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0000); tick();
            hits += int'(bus.hit_valid);
            apply(4'b1000, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000); tick();
            hits += int'(bus.hit_valid);
            apply(4'b1000, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0000); tick();
            hits += int'(bus.hit_valid);
        end
        idle();
        check("t5_hits", hits, 5);
        check_cnt("t5_cnt3_sat", 3, 3);

        // Test 6: asynchronous reset with a pending hit
        do_reset();
        apply(4'b0001, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000); tick();
        apply(4'b0001, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000); tick();
        apply(4'b0001, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000); tick();
        check("t6_hit_pending", bus.hit_valid, 1);
        idle();
        clr_n = 1'b0;
        #1;
        check("t6_async_drop", bus.hit_valid, 0);
        check_cnt("t6_cnt0_lost", 0, 0);
        clr_n = 1'b1;
        tick();
        apply(4'b1111, 2'b10, 2'b11, 2'b11, 2'b11, 4'b0000);
        check("t6_ch0_first", bus.req_ready, 4'b0001);
        tick();
        check("t6_no_hit", bus.hit_valid, 0);
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
